seq_multiplier: RTL



---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_datapath.sv | 79 +++++++
 rtl/seq_multiplier.sv | 101 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiply-accumulate unit.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Iteration counter must hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: accumulator, latched operands, iteration counter and adder.
// Optional macro MULT_EARLY_EXIT_EN: last_step also fires once the remaining
// multiplier bits are all zero, so the run ends as soon as nothing is left to add.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     addend,
  output logic [2*WIDTH-1:0]   acc_step,
  output logic                 last_step
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] partial;

  // Accumulator value after the current iteration; max sum fits in 2*WIDTH bits.
  always_comb begin
    mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    partial   = mplier_q[0] ? (mcand_ext << cnt_q) : '0;
    acc_step  = acc_q + partial;
  end

  // Termination condition for the current RUN iteration.
  always_comb begin
`ifdef MULT_EARLY_EXIT_EN
    last_step = (cnt_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  // Next-state for operands, accumulator and counter under load/step control.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = {{WIDTH{1'b0}}, addend};
      mcand_d  = mcand;
      mplier_d = mplier;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = acc_step;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiply-accumulate: product = mcand * mplier + addend,
// one multiplier bit per clock, start/busy/done handshake.
// Optional macro MULT_EARLY_EXIT_EN (handled in mult_datapath) shortens the
// run to the highest set multiplier bit; the product is unchanged.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     addend,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_step;

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .mcand    (mcand),
    .mplier   (mplier),
    .addend   (addend),
    .acc_step (acc_step),
    .last_step(last_step)
  );

  // Control FSM: accepts start only in IDLE; product captures the final sum
  // on the edge entering DONE, so it already includes the last iteration's add.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = acc_step;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
